fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and address width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  instruction-memory request.
REQ-007 imem_addr  output  WIDTH  request address.
REQ-008 imem_ack  input  1  one-cycle acknowledge; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 id_ready  input  1  decode stage accepts instr this cycle.
REQ-011 redirect  input  1  branch, jump or jr taken; one-cycle pulse.
REQ-012 redirect_pc  input  WIDTH  target of redirect.
REQ-013 instr_valid  output  1  instr, instr_pc, op and funct hold a valid instruction.
REQ-014 instr  output  32  registered instruction word.
REQ-015 instr_pc  output  WIDTH  address of instr.
REQ-016 pc_plus4  output  WIDTH  instr_pc + 4, for jal link.
REQ-017 op  output  6  instr[31:26], feeds the main decoder.
REQ-018 funct  output  6  instr[5:0], feeds the main decoder.

Function
REQ-019 SHALL implement the states IDLE, FETCH, BUF and DRAIN.
REQ-020 Memory protocol: imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ack=1, inclusive; an ack in the same cycle as the request (zero-wait) SHALL be legal.
REQ-021 IDLE SHALL drive imem_req=0 and SHALL move to FETCH on the first clock after reset release.
REQ-022 FETCH SHALL drive imem_req=1 and imem_addr=pc.
REQ-023 In FETCH, an ack with the output slot free (instr_valid=0 or id_ready=1) SHALL load instr/instr_pc, set instr_valid, set pc<=pc+4 and stay in FETCH.
REQ-024 In FETCH, an ack with the output slot full SHALL capture the word and its address in a one-entry buffer, set pc<=pc+4 and move to BUF.
REQ-025 BUF SHALL drive imem_req=0; on id_ready=1 the buffer SHALL move to the output register, keep instr_valid=1 and return to FETCH.
REQ-026 instr_valid SHALL clear only on id_ready=1 with no new word loaded; the output registers SHALL not change while instr_valid=1 and id_ready=0.
REQ-027 Sustained throughput SHALL be one instruction per cycle with zero-wait memory and id_ready=1.
REQ-028 pc arithmetic SHALL be modulo 2^WIDTH; increment from 32'hFFFF_FFFC SHALL wrap to 0.
REQ-029 redirect SHALL have priority over every other event: it clears instr_valid and the buffer and sets pc<=redirect_pc in the same edge.
REQ-030 A redirect in FETCH with imem_ack=0 SHALL move to DRAIN.
REQ-031 DRAIN SHALL keep the old request until its ack, discard that data, then move to FETCH at the redirected pc.
REQ-032 A redirect in the same cycle as imem_ack SHALL discard the acked data and stay in FETCH at redirect_pc.
REQ-033 A redirect in BUF or DRAIN SHALL clear the buffer and update pc; DRAIN SHALL still wait for its ack.
REQ-034 A redirect and id_ready in the same cycle SHALL clear instr_valid (flush wins).
REQ-035 op and funct SHALL be combinational slices of the registered instr.

Reset
REQ-036 Asserting rst_n=0 SHALL asynchronously set state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0 and the buffer empty.
REQ-037 Reset asserted mid-request SHALL abandon the request; a late ack arriving in IDLE SHALL be ignored.

Structure
REQ-038 Shared package cpu_pkg SHALL hold the state enum, the opcode constants (RTYPE 000000, LW 000001, SW 000010, ADDI 000011, SUBI 000100, BEQ 000101, J 000111, JAL 001000) and the funct code JR 001000, shared with the decoder.
REQ-039 The output-register-plus-buffer SHALL be one sub-module, ifid_reg; the FSM and PC SHALL stay in fetch_unit.

Verification
REQ-040 Reset release with zero-wait ack and id_ready=1 -> imem_addr sequence 0,4,8,C; instr_valid first high on cycle 3 after reset release.
REQ-041 Word 32'h0400_0000 fetched at pc 0 -> op=000001, funct=000000, instr_pc=0, pc_plus4=4.
REQ-042 Hold id_ready=0 for 3 cycles while acks arrive -> one word in BUF, imem_req=0, instr stable; id_ready=1 delivers buffered word next cycle.
REQ-043 redirect to 32'h100 while the request at 8 waits 2 cycles -> DRAIN, data from 8 discarded, next imem_addr=100.
REQ-044 redirect to 32'h40 in the same cycle as ack at C -> word at C never valid; next imem_addr=40.
REQ-045 pc=32'hFFFF_FFFC with ack -> next imem_addr=0; rst_n low mid-request -> imem_req=0 and instr_valid=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg - definitions shared by the fetch unit and the instruction decoder.
//   fetch_state_e : fetch sequencer states
//   OP_* / FN_*   : opcode and funct encodings seen by the main decoder
//   instr_op()    : opcode field of an instruction word
//   instr_funct() : funct field of an instruction word
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_BUF   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_SUBI  = 6'b000100;
  localparam logic [5:0] OP_BEQ   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b001000;

  localparam logic [5:0] FN_JR    = 6'b001000;

  function automatic logic [5:0] instr_op(input logic [31:0] word);
    return word[31:26];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] word);
    return word[5:0];
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg - fetch-to-decode output register with a one-entry skid buffer.
//   clk, rst_n        : clock, async active-low reset
//   flush             : drop the output word and the buffer (redirect)
//   wr_en/wr_instr/wr_pc : newly acked word and its address
//   id_ready          : decode consumes the output word this cycle
//   instr_valid/instr/instr_pc : registered output word
//   slot_free         : output register can take a word this cycle
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [31:0]      wr_instr,
  input  logic [WIDTH-1:0] wr_pc,
  input  logic             id_ready,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             slot_free
);

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             buf_valid_q, buf_valid_d;
  logic [31:0]      buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;

  assign slot_free   = !valid_q || id_ready;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;

  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    if (flush) begin
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (slot_free) begin
      // The buffer is always older than any new word, so it drains first.
      if (buf_valid_q) begin
        valid_d     = 1'b1;
        instr_d     = buf_instr_q;
        pc_d        = buf_pc_q;
        buf_valid_d = 1'b0;
      end else if (wr_en) begin
        valid_d = 1'b1;
        instr_d = wr_instr;
        pc_d    = wr_pc;
      end else begin
        valid_d = 1'b0;
      end
    end else if (wr_en) begin
      buf_valid_d = 1'b1;
      buf_instr_d = wr_instr;
      buf_pc_d    = wr_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch sequencer: PC, memory request FSM and the
// fetch-to-decode register.
//   clk, rst_n                 : clock, async active-low reset
//   imem_req/imem_addr         : instruction memory request, held until ack
//   imem_ack/imem_rdata        : one-cycle acknowledge with data
//   id_ready                   : decode accepts the current word
//   redirect/redirect_pc       : taken branch/jump pulse and its target
//   instr_valid/instr/instr_pc : word presented to decode
//   pc_plus4                   : instr_pc + 4 (link value)
//   op/funct                   : decoder fields sliced from instr
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | just out of reset, no request
// ST_FETCH | request at pc outstanding
// ST_BUF   | output and buffer both full, request paused
// ST_DRAIN | stale request after redirect, waiting for its ack to discard
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             id_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [5:0]       op,
  output logic [5:0]       funct
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic             wr_en;
  logic             slot_free;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!redirect) begin
            wr_en   = 1'b1;
            pc_d    = pc_q + WIDTH'(4);
            state_d = slot_free ? ST_FETCH : ST_BUF;
          end
        end else if (redirect) begin
          // pc moves to the target, so the in-flight address is kept aside
          // to hold imem_addr stable until the memory answers.
          drain_addr_d = pc_q;
          state_d      = ST_DRAIN;
        end
      end
      ST_BUF: begin
        if (id_ready || redirect) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redirect) pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  ifid_reg #(.WIDTH(WIDTH)) u_ifid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect),
    .wr_en       (wr_en),
    .wr_instr    (imem_rdata),
    .wr_pc       (pc_q),
    .id_ready    (id_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .slot_free   (slot_free)
  );

  assign pc_plus4 = instr_pc + WIDTH'(4);
  assign op       = instr_op(instr);
  assign funct    = instr_funct(instr);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit - randomized scoreboard bench for fetch_unit.
// The driver plays instruction memory and decode; it predicts the delivered
// instruction stream (sequential pc, restarted by redirects/reset) and pushes
// it into a queue. The monitor pops on every decode handshake and compares.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [5:0]  op;
  logic [5:0]  funct;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4), .op(op), .funct(funct)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  int ack_pct = 100, rdy_pct = 100, redir_pct = 0;
  logic        redir_now = 1'b0;
  logic [31:0] redir_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0400_0000;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: memory + decode stimulus, reference model of the fetch stream.
  logic [31:0] exp_fetch = 32'h0;
  logic        drain_pending = 1'b0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        imem_ack = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
      end else begin
        imem_ack   = imem_req && ($urandom_range(0, 99) < ack_pct);
        imem_rdata = mem_word(imem_addr);
        id_ready   = ($urandom_range(0, 99) < rdy_pct);
        if (redir_now) begin
          redirect = 1'b1; redirect_pc = redir_tgt; redir_now = 1'b0;
        end else if ($urandom_range(0, 99) < redir_pct) begin
          redirect = 1'b1; redirect_pc = rand_target();
        end else begin
          redirect = 1'b0;
        end
      end
      #2;
      if (!rst_n) begin
        sb.delete();
        exp_fetch = 32'h0;
        drain_pending = 1'b0;
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) begin
          check("req_held", {31'b0, imem_req}, 32'd1);
          check("addr_held", imem_addr, prev_addr);
        end
        check("valid_vs_model", {31'b0, instr_valid}, {31'b0, sb.size() != 0});
        if (sb.size() >= 2) check("req_low_when_full", {31'b0, imem_req}, 32'd0);
        if (imem_ack && imem_req) begin
          if (drain_pending) begin
            drain_pending = 1'b0;
          end else begin
            check("fetch_addr", imem_addr, exp_fetch);
            if (!redirect) sb.push_back('{pc: exp_fetch, word: mem_word(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
        if (redirect) begin
          sb.delete();
          exp_fetch = redirect_pc;
          if (imem_req && !imem_ack) drain_pending = 1'b1;
        end
        prev_pending = imem_req && !imem_ack;
        prev_addr    = imem_addr;
      end
    end
  end

  // Monitor: compares every word decode accepts, and output stability.
  initial begin
    logic        prev_hold = 1'b0;
    logic [31:0] prev_instr = '0, prev_ipc = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", {31'b0, instr_valid}, 32'd1);
          check("hold_instr", instr, prev_instr);
          check("hold_pc", instr_pc, prev_ipc);
        end
        if (instr_valid && id_ready && !redirect) begin
          n_deliv++;
          if (sb.size() == 0) begin
            check("unexpected_word", instr_pc, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("instr", instr, e.word);
            check("instr_pc", instr_pc, e.pc);
            check("pc_plus4", pc_plus4, e.pc + 32'd4);
            check("op", {26'b0, op}, {26'b0, e.word[31:26]});
            check("funct", {26'b0, funct}, {26'b0, e.word[5:0]});
          end
        end
        prev_hold  = instr_valid && !id_ready && !redirect;
        prev_instr = instr;
        prev_ipc   = instr_pc;
      end
    end
  end

  task automatic settle();
    ack_pct = 100; rdy_pct = 100; redir_pct = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int first_valid;
    int d0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Zero-wait start: first valid on the third cycle, word 0x04000000 at pc 0.
    @(negedge clk);
    #1 rst_n = 1'b1;
    first_valid = 0;
    #3;
    for (int k = 1; k <= 6; k++) begin
      if (instr_valid && first_valid == 0) begin
        first_valid = k;
        check("first_op", {26'b0, op}, 32'd1);
        check("first_funct", {26'b0, funct}, 32'd0);
        check("first_instr_pc", instr_pc, 32'd0);
        check("first_pc_plus4", pc_plus4, 32'd4);
      end
      @(negedge clk);
      #4;
    end
    check("first_valid_cycle", first_valid, 32'd3);
    @(negedge clk);
    d0 = n_deliv;
    repeat (20) @(negedge clk);
    check("throughput", n_deliv - d0, 32'd20);

    // Decode stalls while acks keep coming: buffer fills, requests pause.
    rdy_pct = 0;
    repeat (3) @(negedge clk);
    #2;
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    @(negedge clk);
    settle();

    // Redirect while a request waits, then redirect coincident with an ack.
    ack_pct = 0;
    @(negedge clk);
    redir_now = 1'b1; redir_tgt = 32'h100;
    repeat (2) @(negedge clk);
    ack_pct = 100;
    repeat (6) @(negedge clk);
    redir_now = 1'b1; redir_tgt = 32'h40;
    repeat (6) @(negedge clk);
    redir_now = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    repeat (6) @(negedge clk);

    // Randomized traffic.
    for (int b = 0; b < 15; b++) begin
      ack_pct   = $urandom_range(30, 100);
      rdy_pct   = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 10);
      repeat (100) @(negedge clk);
    end
    settle();

    // Reset in the middle of a request, then a late ack while idle.
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (20) @(negedge clk);
    check("post_reset_delivered", {31'b0, n_deliv > d0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
